// File: rtl/traffic_xsection.sv
// Two-road intersection controller: NS/EW lamp sets with timed phases, all-red clearance,
// a latched pedestrian walk phase and a blinking maintenance mode.
module traffic_xsection #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 5,
    parameter int unsigned ALLRED_T = 2,
    parameter int unsigned PED_T    = 8,
    parameter int unsigned FLASH_T  = 4
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_srt,
    input  logic             in_ped_req,
    input  logic             in_flash,
    output logic             o_ns_green,
    output logic             o_ns_yellow,
    output logic             o_ns_red,
    output logic             o_ew_green,
    output logic             o_ew_yellow,
    output logic             o_ew_red,
    output logic             o_walk,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_NS_G  = 4'd1,
        S_NS_Y  = 4'd2,
        S_AR1   = 4'd3,
        S_EW_G  = 4'd4,
        S_EW_Y  = 4'd5,
        S_AR2   = 4'd6,
        S_WALK  = 4'd7,
        S_FLASH = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ped_q, ped_d;
    logic             blink_q, blink_d;
    logic             dir_q, dir_d;

    // State register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ped_q   <= 1'b0;
            blink_q <= 1'b0;
            dir_q   <= DIR_NS;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ped_q   <= ped_d;
            blink_q <= blink_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state logic; any state change restarts the phase counter
    always_comb begin
        state_d = state_q;
        count_d = count_q + CNT_W'(1);
        ped_d   = ped_q | in_ped_req;
        blink_d = blink_q;
        dir_d   = dir_q;

        if (in_flash && (state_q != S_IDLE)) begin
            if (state_q == S_FLASH) begin
                if (count_q == FLASH_LAST) begin
                    count_d = '0;
                    blink_d = ~blink_q;
                end
            end else begin
                state_d = S_FLASH;
                count_d = '0;
                blink_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    // IDLE is untimed, so the counter is parked at zero
                    count_d = '0;
                    if (in_srt) state_d = S_NS_G;
                end
                S_NS_G: begin
                    if (count_q == GREEN_LAST) begin
                        state_d = S_NS_Y;
                        count_d = '0;
                    end
                end
                S_NS_Y: begin
                    if (count_q == YELLOW_LAST) begin
                        state_d = S_AR1;
                        count_d = '0;
                        dir_d   = DIR_EW;
                    end
                end
                S_EW_G: begin
                    if (count_q == GREEN_LAST) begin
                        state_d = S_EW_Y;
                        count_d = '0;
                    end
                end
                S_EW_Y: begin
                    if (count_q == YELLOW_LAST) begin
                        state_d = S_AR2;
                        count_d = '0;
                        dir_d   = DIR_NS;
                    end
                end
                S_AR1, S_AR2: begin
                    if (count_q == ALLRED_LAST) begin
                        count_d = '0;
                        if (ped_q || in_ped_req) begin
                            // A request on the entry edge itself stays pending for the next all-red
                            state_d = S_WALK;
                            ped_d   = in_ped_req;
                        end else begin
                            state_d = (state_q == S_AR1) ? S_EW_G : S_NS_G;
                        end
                    end
                end
                S_WALK: begin
                    if (count_q == PED_LAST) begin
                        state_d = (dir_q == DIR_NS) ? S_NS_G : S_EW_G;
                        count_d = '0;
                    end
                end
                S_FLASH: begin
                    state_d = S_AR2;
                    count_d = '0;
                    dir_d   = DIR_NS;
                    blink_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Lamp decode of the registered state
    always_comb begin
        o_ns_green  = 1'b0;
        o_ns_yellow = 1'b0;
        o_ns_red    = 1'b0;
        o_ew_green  = 1'b0;
        o_ew_yellow = 1'b0;
        o_ew_red    = 1'b0;
        o_walk      = 1'b0;
        case (state_q)
            S_NS_G: begin
                o_ns_green = 1'b1;
                o_ew_red   = 1'b1;
            end
            S_NS_Y: begin
                o_ns_yellow = 1'b1;
                o_ew_red    = 1'b1;
            end
            S_EW_G: begin
                o_ew_green = 1'b1;
                o_ns_red   = 1'b1;
            end
            S_EW_Y: begin
                o_ew_yellow = 1'b1;
                o_ns_red    = 1'b1;
            end
            S_AR1, S_AR2: begin
                o_ns_red = 1'b1;
                o_ew_red = 1'b1;
            end
            S_WALK: begin
                o_ns_red = 1'b1;
                o_ew_red = 1'b1;
                o_walk   = 1'b1;
            end
            S_FLASH: begin
                o_ns_yellow = blink_q;
                o_ew_red    = blink_q;
            end
            default: ;
        endcase
    end

    assign o_state = state_q;
    assign o_count = count_q;

endmodule
